// File: rtl/ocm_coef_loader.sv
// Streams a block of coefficient words out of OCM port 2 into an ISI channel
// coefficient store, tagging each read so its data lands at the right location.
module ocm_coef_loader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int LOC_W      = 8,
  parameter int ADDR_STEP  = 4,
  parameter int RD_LATENCY = 2,
  parameter int MAX_WORDS  = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LOC_W-1:0]  num_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_mem,
  output logic [LOC_W-1:0]  location,
  output logic [DATA_W-1:0] mem_data,
  output logic              load_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LOC_W-1:0]  MAX_N = LOC_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [LOC_W-1:0]  n_words;
  logic [LOC_W-1:0]  issue_loc;
  logic              start_ok;
  logic              pend;

  // Tag pipe: one stage per OCM read-latency cycle, aligned with mem_rdata.
  logic [RD_LATENCY-1:0] tag_vld_p;
  logic [LOC_W-1:0]      tag_loc_p [RD_LATENCY];

  assign start_ok = (num_words != '0) && (num_words <= MAX_N);
  assign mem_data = mem_rdata;
  assign load_mem = tag_vld_p[RD_LATENCY-1];
  assign location = tag_loc_p[RD_LATENCY-1];

  // Tags still in flight other than the one leaving the pipe this cycle.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LATENCY - 1; i++) pend = pend | tag_vld_p[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      n_words   <= '0;
      issue_loc <= '0;
      tag_vld_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_loc_p[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      tag_vld_p[0] <= mem_read;
      tag_loc_p[0] <= issue_loc;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_loc_p[i] <= tag_loc_p[i-1];
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (start_ok) begin
              state     <= ISSUE;
              mem_read  <= 1'b1;
              mem_addr  <= base_addr;
              issue_loc <= '0;
              n_words   <= num_words;
              load_done <= 1'b0;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_loc == n_words - LOC_W'(1)) begin
            mem_read <= 1'b0;
            state    <= DRAIN;
          end else begin
            mem_addr  <= mem_addr + STEP;
            issue_loc <= issue_loc + LOC_W'(1);
          end
        end
        DRAIN: begin
          if (!pend) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            load_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides whatever the active state decided this cycle.
      if (abort && state != IDLE) begin
        state     <= IDLE;
        mem_read  <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        load_done <= 1'b0;
        tag_vld_p <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ocm_coef_loader.sv
// Bench for ocm_coef_loader: directed scenarios then random traffic, checked
// every cycle against a schedule-based model of the load timing.
module tb_ocm_coef_loader;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int L  = 2;
  localparam int MAXW = 15;

  logic          clk = 1'b0;
  logic          rstn, start, abort;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_words;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;
  logic          load_mem;
  logic [LW-1:0] location;
  logic [DW-1:0] mem_data;
  logic          load_done, busy, done, err;

  ocm_coef_loader #(
    .ADDR_W(AW), .DATA_W(DW), .LOC_W(LW), .ADDR_STEP(4),
    .RD_LATENCY(L), .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .load_mem(load_mem), .location(location), .mem_data(mem_data),
    .load_done(load_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // OCM model: word content is a fixed function of address, returned L cycles later.
  function automatic logic [DW-1:0] ocm_word(input logic [AW-1:0] a);
    return {~a, 2'b10, a, 16'hBEEF, a, 4'h5};
  endfunction

  logic [AW-1:0] addr_hist [L];
  always @(posedge clk) begin
    addr_hist[0] <= mem_addr;
    for (int i = 1; i < L; i++) addr_hist[i] <= addr_hist[i-1];
  end
  assign mem_rdata = ocm_word(addr_hist[L-1]);

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, t);
    end
  endtask

  // Reference model: one load record plus sticky/pulse flags.
  logic          m_active = 1'b0;
  int            m_c0 = 0;
  logic [AW-1:0] m_base = '0;
  int            m_n = 0;
  logic          m_ld_done = 1'b0;
  logic          m_err = 1'b0;
  logic          m_rst = 1'b0;
  logic          m_busy = 1'b0;

  task automatic model_edge(input logic s, input logic a, input logic r,
                            input logic [AW-1:0] b, input logic [LW-1:0] n);
    if (!r) begin
      m_active = 1'b0; m_ld_done = 1'b0; m_err = 1'b0; m_rst = 1'b1;
    end else if (m_busy) begin
      if (a) begin m_active = 1'b0; m_ld_done = 1'b0; end
    end else if (s && !a) begin
      if (n >= 1 && n <= MAXW) begin
        m_active = 1'b1; m_c0 = t + 1; m_base = b; m_n = int'(n); m_ld_done = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic eval_check();
    int   rel;
    logic e_read, e_lm, e_busy, e_done;
    rel    = t - m_c0 + 1;
    e_read = m_active && rel >= 1 && rel <= m_n;
    e_lm   = m_active && rel >= 1 + L && rel <= m_n + L;
    e_busy = m_active && rel >= 1 && rel <= m_n + L;
    e_done = 1'b0;
    if (m_active && rel == m_n + L + 1) begin
      e_done = 1'b1; m_active = 1'b0; m_ld_done = 1'b1;
    end
    check("mem_read", 64'(mem_read), 64'(e_read));
    check("load_mem", 64'(load_mem), 64'(e_lm));
    check("busy", 64'(busy), 64'(e_busy));
    check("done", 64'(done), 64'(e_done));
    check("err", 64'(err), 64'(m_err));
    check("load_done", 64'(load_done), 64'(m_ld_done));
    if (e_read) check("mem_addr", 64'(mem_addr), 64'(AW'(m_base + AW'((rel - 1) * 4))));
    if (e_lm) begin
      check("location", 64'(location), 64'(rel - 1 - L));
      check("mem_data", mem_data, ocm_word(AW'(m_base + AW'((rel - 1 - L) * 4))));
    end
    if (m_rst) begin
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_location", 64'(location), 64'(0));
    end
    m_busy = e_busy;
    m_err  = 1'b0;
    m_rst  = 1'b0;
  endtask

  task automatic cyc(input logic s, input logic a, input logic r,
                     input logic [AW-1:0] b, input logic [LW-1:0] n);
    start = s; abort = a; rstn = r; base_addr = b; num_words = n;
    model_edge(s, a, r, b, n);
    @(posedge clk);
    t++;
    @(negedge clk);
    eval_check();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; rstn = 1'b0; base_addr = '0; num_words = '0;
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
    idle(2);
    // Basic load and address wrap.
    cyc(1'b1, 1'b0, 1'b1, 14'h0000, 8'd3);    idle(8);
    cyc(1'b1, 1'b0, 1'b1, 14'h3FFC, 8'd3);    idle(8);
    // Abort two cycles into a 5-word load.
    cyc(1'b1, 1'b0, 1'b1, 14'h0100, 8'd5);    idle(1);
    cyc(1'b0, 1'b1, 1'b1, '0, '0);            idle(6);
    // Rejected starts, then a start ignored while busy.
    cyc(1'b1, 1'b0, 1'b1, 14'h0040, 8'd0);    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 14'h0040, 8'd16);   idle(2);
    cyc(1'b1, 1'b0, 1'b1, 14'h0200, 8'd4);    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 14'h1000, 8'd2);    idle(8);
    // Abort+start in idle, abort in idle, single-word and max-size loads.
    cyc(1'b1, 1'b1, 1'b1, 14'h0300, 8'd4);    idle(2);
    cyc(1'b0, 1'b1, 1'b1, '0, '0);            idle(1);
    cyc(1'b1, 1'b0, 1'b1, 14'h0010, 8'd1);    idle(5);
    cyc(1'b1, 1'b0, 1'b1, 14'h3FE0, 8'd15);   idle(20);
    // Reset in the middle of an 8-word load, then a clean reload.
    cyc(1'b1, 1'b0, 1'b1, 14'h0400, 8'd8);    idle(2);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);            idle(2);
    cyc(1'b1, 1'b0, 1'b1, 14'h0400, 8'd8);    idle(14);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic          s, a, r;
      logic [AW-1:0] b;
      logic [LW-1:0] n;
      s = ($urandom % 5) == 0;
      a = ($urandom % 30) == 0;
      r = ($urandom % 250) != 0;
      b = ($urandom % 4) == 0 ? AW'(14'h3FF0 + AW'($urandom % 16)) : AW'($urandom);
      n = ($urandom % 8) == 0 ? LW'($urandom_range(0, 20)) : LW'($urandom_range(1, 15));
      cyc(s, a, r, b, n);
    end
    idle(25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ocm_coef_loader.md
OCM_COEF_LOADER -- requirements
Module: ocm_coef_loader

Interface
REQ-001 Parameter ADDR_W, default 14, OCM 64-bit port address width.
REQ-002 Parameter DATA_W, default 64, OCM read data width.
REQ-003 Parameter LOC_W, default 8, coefficient location index width.
REQ-004 Parameter ADDR_STEP, default 4, address increment per word.
REQ-005 Parameter RD_LATENCY, default 2 (legal 1..4), OCM cycles from address to valid readdata.
REQ-006 Parameter MAX_WORDS, default 15, largest legal num_words.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 start  in  1  single-cycle load request.
REQ-010 abort  in  1  cancel an in-progress load.
REQ-011 base_addr  in  ADDR_W  first OCM address, sampled with start.
REQ-012 num_words  in  LOC_W  words to load, sampled with start.
REQ-013 mem_addr  out  ADDR_W  OCM port-2 address.
REQ-014 mem_read  out  1  OCM read strobe (address valid).
REQ-015 mem_rdata  in  DATA_W  OCM port-2 readdata.
REQ-016 load_mem  out  1  write strobe to ISI channel coefficient store.
REQ-017 location  out  LOC_W  coefficient index qualified by load_mem.
REQ-018 mem_data  out  DATA_W  coefficient word; combinational pass-through of mem_rdata.
REQ-019 load_done  out  1  level to channel done_wait; coefficients complete.
REQ-020 busy  out  1  load in progress.
REQ-021 done  out  1  one-cycle pulse at load completion.
REQ-022 err  out  1  one-cycle pulse on rejected start.

Function
REQ-023 FSM states IDLE, ISSUE, DRAIN; done issued as a registered pulse on DRAIN->IDLE.
REQ-024 Cycle numbering: cycle 0 is the edge sampling start=1 in IDLE with 1<=num_words<=MAX_WORDS; N=num_words, L=RD_LATENCY.
REQ-025 Accepted start: IDLE->ISSUE, load_done cleared, word counter and location counter cleared.
REQ-026 ISSUE: mem_read=1 in cycles 1..N; mem_addr=base_addr+k*ADDR_STEP (k=0..N-1) in cycle k+1, modulo 2^ADDR_W.
REQ-027 After issuing word N-1: ISSUE->DRAIN; mem_read=0, mem_addr holds last value.
REQ-028 Each issued read pushes a tag (valid, index) into an L-deep shift pipe; tag emerging drives load_mem=1 and location=index.
REQ-029 load_mem high exactly in cycles 1+L..N+L, location=0..N-1 in order, no gaps.
REQ-030 DRAIN->IDLE when tag pipe empty; done=1 and load_done set in cycle N+L+1.
REQ-031 busy=1 in cycles 1..N+L, 0 otherwise.
REQ-032 load_done stays 1 until next accepted start, abort, or reset.
REQ-033 start with num_words=0 or >MAX_WORDS in IDLE: err=1 next cycle, stay IDLE, load_done unchanged.
REQ-034 start while busy: ignored, no err, no effect on load in progress.
REQ-035 abort while busy: next state IDLE, tag pipe flushed, load_mem=0 from next cycle, mem_read=0, no done, load_done=0.
REQ-036 abort and start in the same cycle: abort wins; start is ignored.
REQ-037 abort in IDLE: no effect.

Reset
REQ-038 rstn=0 at an edge: state IDLE, tag pipe cleared; mem_addr=0, mem_read=0, load_mem=0, location=0, load_done=0, busy=0, done=0, err=0.
REQ-039 Reset mid-load: same values from the next cycle; no done pulse; no further load_mem.

Verification
REQ-040 base=0, N=3, L=2, start at cycle 0 -> mem_addr 0,4,8 in cycles 1-3; load_mem cycles 3-5 with location 0,1,2 and mem_data=OCM words; done and load_done rise in cycle 6.
REQ-041 base=0x3FFC, N=3 -> mem_addr 0x3FFC, 0x0000, 0x0004 (wrap).
REQ-042 N=5, abort at cycle 2 -> load_mem low from cycle 3, busy low from cycle 3, no done, load_done=0.
REQ-043 start with num_words=0, then with 16 -> err pulse each next cycle, busy stays 0; start at cycle 2 of an N=4 load -> ignored, done at cycle 7 (L=2).
REQ-044 rstn=0 at cycle 3 of an N=8 load -> all outputs at reset values from cycle 4; fresh start afterwards completes normally with locations 0..7.
